decode_execute_unit: RTL and testbench

Parametrised, registered successor to the team's 4-bit combinational decode-and-execute datapath. Accepts one instruction per valid/ready handshake, reads operands from an internal register file, executes one of nine operations on WIDTH-bit data, writes the result back and reports it on a one-cycle result strobe. Shifts are variable-distance and iterate one bit per cycle, so the block has real occupancy and backpressure. It sits between an instruction sequencer (upstream) and any result consumer or trace logger (downstream).

---
 rtl/decode_execute_pkg.sv | 23 ++
 rtl/decode_execute_unit_alu_core.sv | 42 ++++
 rtl/decode_execute_unit.sv | 127 ++++++++++++
 tb/tb_decode_execute_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_execute_pkg.sv
// Shared opcode/state encodings for the registered decode-and-execute unit.
package decode_execute_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_SUB = 4'd0,
    OP_ADD = 4'd1,
    OP_OR  = 4'd2,
    OP_AND = 4'd3,
    OP_SRA = 4'd4,
    OP_ROL = 4'd5,
    OP_LT  = 4'd6,
    OP_EQ  = 4'd7,
    OP_LDI = 4'd8
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/decode_execute_unit_alu_core.sv
// Combinational ALU for every single-cycle operation; shifts pass rs through
// so that a zero-distance shift completes like any other single-cycle op.
module alu_core
  import decode_execute_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             err
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // SUB is rs + ~rt + 1, so its carry-out doubles as the unsigned rs >= rt flag
  assign sum  = {1'b0, rs} + {1'b0, rt};
  assign diff = {1'b0, rs} + {1'b0, ~rt} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    err    = 1'b0;
    case (op)
      OP_SUB:  {carry, result} = diff;
      OP_ADD:  {carry, result} = sum;
      OP_OR:   result = rs | rt;
      OP_AND:  result = rs & rt;
      OP_SRA:  result = rs;
      OP_ROL:  result = rs;
      OP_LT:   result = {{(WIDTH-1){1'b0}}, (rs < rt)};
      OP_EQ:   result = {{(WIDTH-1){1'b0}}, (rs == rt)};
      OP_LDI:  result = imm;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_execute_unit.sv
// Registered decode/execute unit: register file, handshake FSM and a
// one-bit-per-cycle shift iterator around the combinational alu_core.
module decode_execute_unit
  import decode_execute_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREG  = 4,
  localparam int IDXW  = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [IDXW-1:0]  in_rd,
  input  logic [IDXW-1:0]  in_rs,
  input  logic [IDXW-1:0]  in_rt,
  input  logic [WIDTH-1:0] in_imm,
  output logic             out_valid,
  output logic [IDXW-1:0]  out_rd,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_err,
  input  logic [IDXW-1:0]  dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] rf [NREG];
  logic [WIDTH-1:0] acc, acc_step;
  logic [SHW-1:0]   cnt;
  logic             shift_rol;
  logic [IDXW-1:0]  shift_rd;

  logic [WIDTH-1:0] rs_val, rt_val, alu_result;
  logic [SHW-1:0]   n;
  logic             alu_carry, alu_err;
  logic             accept, is_shift, start_shift, finish_shift;

  assign rs_val       = rf[in_rs];
  assign rt_val       = rf[in_rt];
  assign n            = rt_val[SHW-1:0];
  assign dbg_data     = rf[dbg_addr];
  assign accept       = in_valid && in_ready;
  assign is_shift     = (in_op == OP_SRA) || (in_op == OP_ROL);
  assign start_shift  = accept && is_shift && (n != '0);
  assign finish_shift = (state == ST_SHIFT) && (cnt == SHW'(1));
  assign acc_step     = shift_rol ? {acc[WIDTH-2:0], acc[WIDTH-1]}
                                  : {acc[WIDTH-1], acc[WIDTH-1:1]};

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op     (in_op),
    .rs     (rs_val),
    .rt     (rt_val),
    .imm    (in_imm),
    .result (alu_result),
    .carry  (alu_carry),
    .err    (alu_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_shift)  state_nxt = ST_SHIFT;
      ST_SHIFT: if (finish_shift) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE);
  end

  // Reset aborts any shift in flight; the register file only changes on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      acc       <= '0;
      cnt       <= '0;
      shift_rol <= 1'b0;
      shift_rd  <= '0;
      out_valid <= 1'b0;
      out_rd    <= '0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b1;
      out_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (start_shift) begin
        acc       <= rs_val;
        cnt       <= n;
        shift_rol <= (in_op == OP_ROL);
        shift_rd  <= in_rd;
      end else if (accept) begin
        if (!alu_err) rf[in_rd] <= alu_result;
        out_valid <= 1'b1;
        out_rd    <= in_rd;
        out_data  <= alu_result;
        out_carry <= alu_carry;
        out_zero  <= (alu_result == '0);
        out_err   <= alu_err;
      end else if (state == ST_SHIFT) begin
        acc <= acc_step;
        cnt <= cnt - SHW'(1);
        if (finish_shift) begin
          rf[shift_rd] <= acc_step;
          out_valid    <= 1'b1;
          out_rd       <= shift_rd;
          out_data     <= acc_step;
          out_carry    <= 1'b0;
          out_zero     <= (acc_step == '0);
          out_err      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_execute_unit.sv
// Self-checking bench: directed scenarios plus random instructions compared
// against an arithmetic reference model of the register file.
module tb_decode_execute_unit;
  import decode_execute_pkg::*;

  localparam int W  = 8;
  localparam int NR = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = '0;
  logic [IW-1:0] in_rd = '0, in_rs = '0, in_rt = '0;
  logic [W-1:0]  in_imm = '0;
  logic          out_valid;
  logic [IW-1:0] out_rd;
  logic [W-1:0]  out_data;
  logic          out_carry, out_zero, out_err;
  logic [IW-1:0] dbg_addr = '0;
  logic [W-1:0]  dbg_data;

  int model_rf [NR];
  int nerr = 0;
  int nchk = 0;

  decode_execute_unit #(.WIDTH(W), .NREG(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_rd    (out_rd),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .out_err   (out_err),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference semantics computed directly from the instruction definitions
  function automatic void model_exec(input int op, input int a, input int b, input int imm,
                                     output int res, output int carry, output int err);
    int mask = (1 << W) - 1;
    int n    = b % W;
    int sa;
    res = 0; carry = 0; err = 0;
    case (op)
      0: begin res = (a - b) & mask; carry = (a >= b) ? 1 : 0; end
      1: begin res = (a + b) & mask; carry = ((a + b) > mask) ? 1 : 0; end
      2: res = a | b;
      3: res = a & b;
      4: begin sa = (a >= (1 << (W-1))) ? a - (1 << W) : a; res = (sa >>> n) & mask; end
      5: res = ((a << n) | (a >> (W - n))) & mask;
      6: res = (a < b) ? 1 : 0;
      7: res = (a == b) ? 1 : 0;
      8: res = imm & mask;
      default: err = 1;
    endcase
  endfunction

  task automatic check_output(input int rd, input int res, input int carry, input int err);
    chk("out_valid", out_valid, 1);
    chk("out_rd", out_rd, rd);
    chk("out_data", out_data, res);
    chk("out_carry", out_carry, carry);
    chk("out_zero", out_zero, (res == 0) ? 1 : 0);
    chk("out_err", out_err, err);
    chk("ready_after", in_ready, 1);
  endtask

  task automatic check_rf();
    for (int i = 0; i < NR; i++) begin
      dbg_addr = IW'(i);
      #1;
      chk("dbg_rf", dbg_data, model_rf[i]);
    end
  endtask

  task automatic check_idle();
    @(posedge clk); #1;
    chk("strobe_low", out_valid, 0);
  endtask

  // Issue one instruction, verify busy timing and the result strobe
  task automatic apply_stimulus(input int op, input int rd, input int rs, input int rt,
                                input int imm, input bit keep, input bit hold_busy);
    int res, carry, err, n, lat;
    model_exec(op, model_rf[rs], model_rf[rt], imm, res, carry, err);
    n   = model_rf[rt] % W;
    lat = ((op == 4 || op == 5) && n != 0) ? n : 0;
    @(negedge clk);
    in_op = 4'(op); in_rd = IW'(rd); in_rs = IW'(rs); in_rt = IW'(rt);
    in_imm = W'(imm); in_valid = 1'b1;
    @(posedge clk); #1;
    if (lat > 0) begin
      if (hold_busy) begin
        in_op = 4'd8; in_rd = IW'((rd + 1) % NR); in_imm = 8'hAA;
      end else begin
        in_valid = 1'b0;
      end
      for (int k = 0; k < lat; k++) begin
        chk("busy_ready", in_ready, 0);
        chk("busy_strobe", out_valid, 0);
        @(posedge clk); #1;
      end
    end
    if (!keep) in_valid = 1'b0;
    check_output(rd, res, carry, err);
    if (err == 0) model_rf[rd] = res;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) model_rf[i] = 0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_carry", out_carry, 0);
    chk("rst_zero", out_zero, 1);
    chk("rst_err", out_err, 0);
    check_rf();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid2", out_valid, 0);

    $display("[TB] subtract and carry");
    apply_stimulus(8, 1, 0, 0, 8'h05, 0, 0);
    apply_stimulus(8, 2, 0, 0, 8'h03, 0, 0);
    apply_stimulus(0, 3, 1, 2, 0, 0, 0);
    apply_stimulus(0, 0, 2, 1, 0, 0, 0);
    check_idle();

    $display("[TB] back-to-back add");
    apply_stimulus(8, 1, 0, 0, 8'hFF, 1, 0);
    apply_stimulus(8, 2, 0, 0, 8'h01, 1, 0);
    apply_stimulus(1, 3, 1, 2, 0, 0, 0);
    check_idle();

    $display("[TB] shifts");
    apply_stimulus(8, 1, 0, 0, 8'h90, 0, 0);
    apply_stimulus(8, 2, 0, 0, 8'h03, 0, 0);
    apply_stimulus(4, 3, 1, 2, 0, 0, 0);
    apply_stimulus(5, 3, 1, 2, 0, 0, 0);
    apply_stimulus(8, 2, 0, 0, 8'h08, 0, 0);
    apply_stimulus(4, 3, 1, 2, 0, 0, 0);
    apply_stimulus(8, 2, 0, 0, 8'h0F, 0, 0);
    apply_stimulus(5, 3, 1, 2, 0, 0, 1);
    check_idle();
    check_rf();

    $display("[TB] illegal, LT, EQ");
    apply_stimulus(8, 1, 0, 0, 8'h05, 0, 0);
    apply_stimulus(8, 2, 0, 0, 8'h03, 0, 0);
    apply_stimulus(12, 0, 1, 2, 8'h77, 0, 0);
    check_rf();
    apply_stimulus(6, 0, 2, 1, 0, 0, 0);
    apply_stimulus(7, 0, 1, 1, 0, 0, 0);

    $display("[TB] random instructions");
    for (int i = 0; i < 40; i++) begin
      int op;
      op = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = 8;
      apply_stimulus(op, int'($urandom_range(0, NR-1)), int'($urandom_range(0, NR-1)),
                     int'($urandom_range(0, NR-1)), int'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check_idle();
    check_rf();

    $display("[TB] reset during shift");
    apply_stimulus(8, 1, 0, 0, 8'h90, 0, 0);
    apply_stimulus(8, 2, 0, 0, 8'h0F, 0, 0);
    @(negedge clk);
    in_op = 4'd4; in_rd = 2'd3; in_rs = 2'd1; in_rt = 2'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_busy", in_ready, 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model_rf[i] = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    check_rf();
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("post_rst_strobe", out_valid, 0);
    end
    chk("post_rst_ready", in_ready, 1);
    check_rf();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
